// File: rtl/argmax_if.sv
// Bundle between argmax_unit, its logit memory and the result display path.
// The slave modport is the engine side; master is the memory/display side.
interface argmax_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  start;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  done;
  logic [3:0]            argmax_output;
  logic [DATA_WIDTH-1:0] max_value;

  modport slave (
    input  start,
    input  mem_rdata,
    output mem_rd_en,
    output mem_addr,
    output busy,
    output done,
    output argmax_output,
    output max_value
  );

  modport master (
    output start,
    output mem_rdata,
    input  mem_rd_en,
    input  mem_addr,
    input  busy,
    input  done,
    input  argmax_output,
    input  max_value
  );
endinterface

// File: rtl/argmax_unit.sv
// Sequential argmax over NUM_CLASSES signed logits held in a synchronous-read
// memory; publishes the winning index and value with a one-cycle done pulse.
module argmax_unit #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 4
) (
  input  logic     clk,
  input  logic     reset,
  argmax_if.slave  bus
);
  localparam int unsigned IDX_WIDTH = 4;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CLASSES - 1);
  localparam logic [IDX_WIDTH-1:0]  IDLE_IDX  = 4'hF;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic                         rd_en_q, rd_en_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]        idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [ADDR_WIDTH-1:0]        run_idx_q, run_idx_d;
  logic [IDX_WIDTH-1:0]         out_idx_q, out_idx_d;
  logic signed [DATA_WIDTH-1:0] out_max_q, out_max_d;
  logic                         take_c;

  // Index 0 seeds the running max; later words must be strictly greater so
  // ties keep the lowest index.
  assign take_c = vld_q &&
                  ((idx_q == '0) || ($signed(bus.mem_rdata) > run_max_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      idx_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      out_idx_q <= IDLE_IDX;
      out_max_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      idx_q     <= idx_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      out_idx_q <= out_idx_d;
      out_max_q <= out_max_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    vld_d     = rd_en_q;
    idx_d     = addr_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    out_idx_d = out_idx_q;
    out_max_d = out_max_q;

    if (take_c) begin
      run_max_d = $signed(bus.mem_rdata);
      run_idx_d = idx_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          addr_d  = '0;
          vld_d   = 1'b0;
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Final word is compared on this edge, so publish the post-compare winner.
        state_d   = DONE;
        out_idx_d = IDX_WIDTH'(run_idx_d);
        out_max_d = run_max_d;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_en_d = (state_d == READ);
    busy_d  = (state_d == READ) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  assign bus.mem_rd_en     = rd_en_q;
  assign bus.mem_addr      = addr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.argmax_output = out_idx_q;
  assign bus.max_value     = out_max_q;
endmodule

// File: tb/tb_argmax_unit.sv
// Directed bench for argmax_unit: a behavioural synchronous-read logit memory
// plus hand-computed expected indices, values and cycle positions.
module tb_argmax_unit;
  localparam int N  = 10;
  localparam int DW = 32;
  localparam int AW = 4;

  typedef logic signed [DW-1:0] vec_t [N];

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;
  logic signed [DW-1:0] mem [16];
  vec_t v_basic, v_neg, v_ties, v_last;

  argmax_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  argmax_unit #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read logit memory: data valid the cycle after the address.
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic load(input vec_t v);
    for (int i = 0; i < 16; i++) mem[i] = (i < N) ? v[i] : '0;
  endtask

  // One full scan from a start pulse; returns observations for the caller to judge.
  task automatic run_scan(output int done_edge, output int addr_bad, output int held_bad,
                          output logic [3:0] idx, output logic [DW-1:0] mx,
                          output logic done_next);
    logic [3:0]    idx0;
    logic [DW-1:0] mx0;
    @(negedge clk);
    idx0 = bus.argmax_output;
    mx0  = bus.max_value;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_edge = -1;
    addr_bad  = 0;
    held_bad  = 0;
    for (int j = 0; j < 40; j++) begin
      if (j < N && (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== AW'(j) || bus.busy !== 1'b1))
        addr_bad++;
      if (j == N && (bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b1)) addr_bad++;
      if (bus.done === 1'b1) begin
        done_edge = j;
        break;
      end
      if (bus.argmax_output !== idx0 || bus.max_value !== mx0) held_bad++;
      @(negedge clk);
    end
    idx = bus.argmax_output;
    mx  = bus.max_value;
    @(negedge clk);
    done_next = bus.done;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vecs++; if (bus.argmax_output !== 4'hF) begin errs++; $display("FAIL reset_idx: got %h expected f", bus.argmax_output); end
    vecs++; if (bus.max_value !== '0) begin errs++; $display("FAIL reset_max: got %h expected 0", bus.max_value); end
    vecs++; if ({bus.done, bus.busy, bus.mem_rd_en} !== 3'b000) begin errs++; $display("FAIL reset_ctrl: got done/busy/rd=%b expected 000", {bus.done, bus.busy, bus.mem_rd_en}); end
    vecs++; if (bus.mem_addr !== '0) begin errs++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr); end
  endtask

  task automatic test_idle;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vecs++;
      if (bus.argmax_output !== 4'hF || bus.done !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
        errs++;
        $display("FAIL idle_hold cycle %0d: got idx=%h done=%b rd=%b expected f/0/0", c, bus.argmax_output, bus.done, bus.mem_rd_en);
      end
    end
  endtask

  task automatic test_scan(input string name, input vec_t v, input logic [3:0] e_idx, input logic [DW-1:0] e_max);
    int de, ab, hb;
    logic [3:0] idx;
    logic [DW-1:0] mx;
    logic dn;
    load(v);
    run_scan(de, ab, hb, idx, mx, dn);
    vecs++; if (de !== N + 1) begin errs++; $display("FAIL %s done_edge: got %0d expected %0d", name, de, N + 1); end
    vecs++; if (ab !== 0) begin errs++; $display("FAIL %s addr_seq: got %0d bad cycles expected 0", name, ab); end
    vecs++; if (hb !== 0) begin errs++; $display("FAIL %s outputs_held: got %0d changes expected 0", name, hb); end
    vecs++; if (idx !== e_idx) begin errs++; $display("FAIL %s argmax: got %0d expected %0d", name, idx, e_idx); end
    vecs++; if (mx !== e_max) begin errs++; $display("FAIL %s max_value: got %h expected %h", name, mx, e_max); end
    vecs++; if (dn !== 1'b0) begin errs++; $display("FAIL %s done_width: got %b expected 0", name, dn); end
  endtask

  task automatic test_midscan_start;
    int ndone = 0;
    load(v_basic);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 40; j++) begin
      bus.start = (j == 4);
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    vecs++; if (ndone !== 1) begin errs++; $display("FAIL midscan_done_count: got %0d expected 1", ndone); end
    vecs++; if (bus.argmax_output !== 4'd2) begin errs++; $display("FAIL midscan_argmax: got %0d expected 2", bus.argmax_output); end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    int pos [3] = '{0, 0, 0};
    logic [3:0] got [3] = '{4'h0, 4'h0, 4'h0};
    load(v_ties);
    @(negedge clk);
    bus.start = 1'b1;
    for (int j = 0; j < 60 && ndone < 3; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pos[ndone] = j;
        got[ndone] = bus.argmax_output;
        ndone++;
        if (ndone == 1) load(v_basic);
        else if (ndone == 2) load(v_neg);
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (ndone !== 3) begin errs++; $display("FAIL b2b_done_count: got %0d expected 3", ndone); end
    vecs++; if (pos[1] - pos[0] !== N + 3) begin errs++; $display("FAIL b2b_period1: got %0d expected %0d", pos[1] - pos[0], N + 3); end
    vecs++; if (pos[2] - pos[1] !== N + 3) begin errs++; $display("FAIL b2b_period2: got %0d expected %0d", pos[2] - pos[1], N + 3); end
    vecs++; if (got[0] !== 4'd1) begin errs++; $display("FAIL b2b_result0: got %0d expected 1", got[0]); end
    vecs++; if (got[1] !== 4'd2) begin errs++; $display("FAIL b2b_result1: got %0d expected 2", got[1]); end
    vecs++; if (got[2] !== 4'd1) begin errs++; $display("FAIL b2b_result2: got %0d expected 1", got[2]); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_stops: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_midscan;
    int ndone = 0;
    test_scan("pre_abort", v_basic, 4'd2, 32'd12);
    load(v_ties);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < 5; j++) @(negedge clk);
    vecs++; if (bus.mem_addr !== AW'(5)) begin errs++; $display("FAIL abort_at_addr: got %0d expected 5", bus.mem_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vecs++; if (bus.argmax_output !== 4'hF) begin errs++; $display("FAIL abort_idx: got %h expected f", bus.argmax_output); end
    vecs++; if (bus.max_value !== '0) begin errs++; $display("FAIL abort_max: got %h expected 0", bus.max_value); end
    vecs++; if ({bus.done, bus.busy, bus.mem_rd_en} !== 3'b000) begin errs++; $display("FAIL abort_ctrl: got done/busy/rd=%b expected 000", {bus.done, bus.busy, bus.mem_rd_en}); end
    vecs++; if (bus.mem_addr !== '0) begin errs++; $display("FAIL abort_addr: got %0d expected 0", bus.mem_addr); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    vecs++; if (ndone !== 0) begin errs++; $display("FAIL abort_no_done: got %0d active cycles expected 0", ndone); end
    test_scan("post_abort", v_ties, 4'd1, 32'd9);
  endtask

  initial begin
    v_basic = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
    v_neg   = '{-9, -2, -7, -20, -30, -40, -50, -60, -70, -100};
    v_ties  = '{4, 9, 9, 1, 9, 0, 0, 0, 0, 0};
    v_last  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'sh7FFF_FFFF};
    load(v_basic);
    bus.start = 1'b0;
    reset = 1'b1;

    test_reset;
    test_idle;
    test_scan("basic", v_basic, 4'd2, 32'd12);
    test_scan("negative", v_neg, 4'd1, 32'hFFFF_FFFE);
    test_scan("ties", v_ties, 4'd1, 32'd9);
    test_scan("last_index", v_last, 4'd9, 32'h7FFF_FFFF);
    test_midscan_start;
    test_back_to_back;
    test_reset_midscan;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/argmax_unit.md
# argmax_unit

Sequential argmax engine between the output-layer activation memory and the result display path. On `start` it reads `NUM_CLASSES` signed logits from a synchronous-read memory and finds the index of the largest one. It then presents that index on `argmax_output` with a one-cycle `done` pulse. The index feeds the seven-segment decoder, so its reset/idle value of 4'hF blanks the display.

## Interface
- `NUM_CLASSES`, 10, number of logits to scan (2..16)
- `DATA_WIDTH`, 32, logit width, signed two's complement
- `ADDR_WIDTH`, 4, logit memory address width
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a scan; sampled only in IDLE
- `mem_rd_en`  out  1  memory read enable
- `mem_addr`  out  ADDR_WIDTH  logit address
- `mem_rdata`  in  DATA_WIDTH  logit data, valid the cycle after `mem_addr`/`mem_rd_en`
- `busy`  out  1  high in READ and DRAIN
- `done`  out  1  one-cycle pulse when a result is committed
- `argmax_output`  out  4  index of the maximum logit; held until the next commit
- `max_value`  out  DATA_WIDTH  value of the maximum logit; held with `argmax_output`

## Operation
- States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: outputs quiescent. `start`=1 at an edge loads addr counter=0, valid-pipe=0, and moves to READ.
- READ: `mem_rd_en`=1, `mem_addr`=counter, counter increments every cycle. After issuing address NUM_CLASSES-1, move to DRAIN.
- DRAIN: `mem_rd_en`=0. Consume the final data word, then move to DONE.
- Compare pipeline:
  - A 1-bit valid flag and an index register trail the address by one cycle.
  - On each valid data cycle, index 0 loads the running max unconditionally.
  - Later indices replace the running max only if `$signed(mem_rdata) > $signed(running_max)`, strictly greater.
  - Ties therefore resolve to the lowest index.
- DONE: `argmax_output` and `max_value` are loaded from the running registers at the edge entering DONE. `done`=1 for exactly that one cycle, then IDLE.
- The running registers are internal. Published outputs do not change mid-scan.
- `start` in READ, DRAIN or DONE is ignored, not queued.
- `start` held high re-triggers a new scan on every IDLE cycle. Back-to-back scans are legal.
- The final index is 4 bits wide; `NUM_CLASSES` > 16 is unsupported.

## Timing
- Reset values (the cycle after any edge with `reset`=1):
  - state=IDLE
  - `argmax_output`=4'hF
  - `max_value`=0
  - `done`=0, `busy`=0, `mem_rd_en`=0, `mem_addr`=0
- Reset mid-scan aborts immediately. No `done` is issued, and the previous result is cleared to reset values.
- Let E0 be the edge sampling `start`. Address k is driven in the cycle after edge E0+k, for k=0..N-1.
- Data k is compared at edge E0+k+2.
- `done` and the new outputs appear after edge E0+N+1: 11 edges for N=10.
- The next `start` can be sampled at edge E0+N+3.
- `reset` has priority over `start` at the same edge.

## Test plan
- Reset, then idle with no `start` -> `argmax_output`=4'hF, `done`=0, `mem_rd_en`=0, all held for 20 cycles.
- Logits {5,-3,12,7,0,1,2,3,4,11}, pulse `start` -> addresses 0..9 on consecutive cycles, `done` one cycle exactly 11 edges after start, `argmax_output`=2, `max_value`=12.
- All logits negative {-9,-2,-7,...,-100} -> `argmax_output`=1, `max_value`=-2. Checks signed compare; an unsigned compare would fail.
- Ties {4,9,9,1,9,0,0,0,0,0} -> `argmax_output`=1. Also max at last index {0,...,0,0x7FFFFFFF} -> 9.
- `start` pulsed during READ and `start` held high continuously -> mid-scan pulse ignored (one `done`); held start gives a `done` every N+3 cycles with correct results.
- `reset` asserted at address 5 of a scan following a completed result of 2 -> next cycle all outputs at reset values, no `done`; a fresh scan afterwards completes normally.
